// File: rtl/exc_encode.sv
// Exception cause encoder: carries per-stage exception codes down a D/E/M
// shadow pipeline, resolves the cause at M and holds a request until CP0 acks.
module exc_encode #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            f_valid,
  input  logic [PC_W-1:0] f_pc,
  input  logic            addr_err_f,
  input  logic            cache_err_f,
  input  logic            bus_err_f,
  input  logic            cp0_unused,
  input  logic            instr_undefine,
  input  logic            syscall,
  input  logic            break_point,
  input  logic            overflow,
  input  logic            trap,
  input  logic            addr_err_m,
  input  logic            cache_err_m,
  input  logic            bus_err_m,
  input  logic            exc_ack,
  output logic            exc_req,
  output logic [4:0]      excode,
  output logic [PC_W-1:0] exc_epc,
  output logic            flush
);

  localparam int unsigned CODE_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                d_valid_q, d_valid_d;
  logic [PC_W-1:0]     d_pc_q, d_pc_d;
  logic [CODE_W-1:0]   d_code_q, d_code_d;
  logic                e_valid_q, e_valid_d;
  logic [PC_W-1:0]     e_pc_q, e_pc_d;
  logic [CODE_W-1:0]   e_code_q, e_code_d;
  logic                m_valid_q, m_valid_d;
  logic [PC_W-1:0]     m_pc_q, m_pc_d;
  logic [CODE_W-1:0]   m_code_q, m_code_d;
  logic [CODE_W-1:0]   excode_q, excode_d;
  logic [PC_W-1:0]     epc_q, epc_d;

  logic [CODE_W-1:0]   enc_f, enc_d, enc_e, enc_m, code_m;

  // Fetch-stage encoder: lowest code wins, gated by the stage valid
  always_comb begin
    enc_f = '0;
    if (f_valid) begin
      if (addr_err_f)       enc_f = CODE_W'(1);
      else if (cache_err_f) enc_f = CODE_W'(2);
      else if (bus_err_f)   enc_f = CODE_W'(3);
    end
  end

  // Decode-stage encoder
  always_comb begin
    enc_d = '0;
    if (d_valid_q) begin
      if (cp0_unused)          enc_d = CODE_W'(4);
      else if (instr_undefine) enc_d = CODE_W'(5);
      else if (syscall)        enc_d = CODE_W'(8);
      else if (break_point)    enc_d = CODE_W'(9);
    end
  end

  // Execute-stage encoder
  always_comb begin
    enc_e = '0;
    if (e_valid_q) begin
      if (overflow)  enc_e = CODE_W'(6);
      else if (trap) enc_e = CODE_W'(7);
    end
  end

  // Memory-stage encoder and commit resolution (earlier cause dominates)
  always_comb begin
    enc_m = '0;
    if (m_valid_q) begin
      if (addr_err_m)       enc_m = CODE_W'(10);
      else if (cache_err_m) enc_m = CODE_W'(11);
      else if (bus_err_m)   enc_m = CODE_W'(12);
    end
    code_m = (m_code_q != '0) ? m_code_q : enc_m;
  end

  // Next-state: shadow pipeline advance, commit and request handshake
  always_comb begin
    state_d   = state_q;
    d_valid_d = d_valid_q;
    d_pc_d    = d_pc_q;
    d_code_d  = d_code_q;
    e_valid_d = e_valid_q;
    e_pc_d    = e_pc_q;
    e_code_d  = e_code_q;
    m_valid_d = m_valid_q;
    m_pc_d    = m_pc_q;
    m_code_d  = m_code_q;
    excode_d  = excode_q;
    epc_d     = epc_q;

    case (state_q)
      IDLE: begin
        if (!stall) begin
          if (m_valid_q && (code_m != '0)) begin
            // Commit: latch cause and squash everything younger
            state_d   = REQ;
            excode_d  = code_m;
            epc_d     = m_pc_q;
            d_valid_d = 1'b0;
            e_valid_d = 1'b0;
            m_valid_d = 1'b0;
          end else begin
            d_valid_d = f_valid;
            d_pc_d    = f_pc;
            d_code_d  = enc_f;
            e_valid_d = d_valid_q;
            e_pc_d    = d_pc_q;
            e_code_d  = (d_code_q != '0) ? d_code_q : enc_d;
            m_valid_d = e_valid_q;
            m_pc_d    = e_pc_q;
            m_code_d  = (e_code_q != '0) ? e_code_q : enc_e;
          end
        end
      end
      REQ: begin
        // Valids stay cleared; only the ack matters here
        if (exc_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      d_valid_q <= 1'b0;
      d_pc_q    <= '0;
      d_code_q  <= '0;
      e_valid_q <= 1'b0;
      e_pc_q    <= '0;
      e_code_q  <= '0;
      m_valid_q <= 1'b0;
      m_pc_q    <= '0;
      m_code_q  <= '0;
      excode_q  <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      d_valid_q <= d_valid_d;
      d_pc_q    <= d_pc_d;
      d_code_q  <= d_code_d;
      e_valid_q <= e_valid_d;
      e_pc_q    <= e_pc_d;
      e_code_q  <= e_code_d;
      m_valid_q <= m_valid_d;
      m_pc_q    <= m_pc_d;
      m_code_q  <= m_code_d;
      excode_q  <= excode_d;
      epc_q     <= epc_d;
    end
  end

  assign exc_req = (state_q == REQ);
  assign flush   = (state_q == REQ);
  assign excode  = excode_q;
  assign exc_epc = epc_q;

endmodule

// File: tb/tb_exc_encode.sv
// Directed bench for exc_encode: table of single-instruction faults plus
// hand-written reset, stall, squash and async-reset sequences.
module tb_exc_encode;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        addr_err_f, cache_err_f, bus_err_f;
  logic        cp0_unused, instr_undefine, syscall, break_point;
  logic        overflow, trap;
  logic        addr_err_m, cache_err_m, bus_err_m;
  logic        exc_ack;
  logic        exc_req;
  logic [4:0]  excode;
  logic [31:0] exc_epc;
  logic        flush;

  int checks = 0;
  int errors = 0;

  exc_encode #(.PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .f_valid(f_valid), .f_pc(f_pc),
    .addr_err_f(addr_err_f), .cache_err_f(cache_err_f), .bus_err_f(bus_err_f),
    .cp0_unused(cp0_unused), .instr_undefine(instr_undefine),
    .syscall(syscall), .break_point(break_point),
    .overflow(overflow), .trap(trap),
    .addr_err_m(addr_err_m), .cache_err_m(cache_err_m), .bus_err_m(bus_err_m),
    .exc_ack(exc_ack),
    .exc_req(exc_req), .excode(excode), .exc_epc(exc_epc), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // f = {addr,cache,bus}, d = {cp0,undef,sys,brk}, e = {ovf,trap}, m = {addr,cache,bus}
  typedef struct {
    logic [2:0]  f;
    logic [3:0]  d;
    logic [1:0]  e;
    logic [2:0]  m;
    logic [31:0] pc;
    logic [4:0]  code;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    {addr_err_f, cache_err_f, bus_err_f} = 3'b000;
    {cp0_unused, instr_undefine, syscall, break_point} = 4'b0000;
    {overflow, trap} = 2'b00;
    {addr_err_m, cache_err_m, bus_err_m} = 3'b000;
  endtask

  task automatic do_ack();
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("ack_req", 32'(exc_req), 32'd0);
    check("ack_flush", 32'(flush), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{f:3'b011, d:4'b0000, e:2'b00, m:3'b000, pc:32'h100, code:5'd2};
    vecs[1]  = '{f:3'b101, d:4'b0000, e:2'b00, m:3'b000, pc:32'h104, code:5'd1};
    vecs[2]  = '{f:3'b000, d:4'b0010, e:2'b10, m:3'b001, pc:32'h200, code:5'd8};
    vecs[3]  = '{f:3'b000, d:4'b0011, e:2'b00, m:3'b000, pc:32'h204, code:5'd8};
    vecs[4]  = '{f:3'b000, d:4'b1110, e:2'b00, m:3'b000, pc:32'h208, code:5'd4};
    vecs[5]  = '{f:3'b000, d:4'b0000, e:2'b11, m:3'b000, pc:32'h20c, code:5'd6};
    vecs[6]  = '{f:3'b000, d:4'b0000, e:2'b01, m:3'b000, pc:32'h210, code:5'd7};
    vecs[7]  = '{f:3'b000, d:4'b0000, e:2'b00, m:3'b011, pc:32'h214, code:5'd11};
    vecs[8]  = '{f:3'b000, d:4'b0000, e:2'b00, m:3'b100, pc:32'h218, code:5'd10};
    vecs[9]  = '{f:3'b000, d:4'b0000, e:2'b00, m:3'b001, pc:32'h21c, code:5'd12};
    vecs[10] = '{f:3'b000, d:4'b0000, e:2'b00, m:3'b000, pc:32'h220, code:5'd0};
    vecs[11] = '{f:3'b000, d:4'b0001, e:2'b00, m:3'b100, pc:32'h224, code:5'd9};
    vecs[12] = '{f:3'b001, d:4'b1000, e:2'b00, m:3'b000, pc:32'h228, code:5'd3};

    rst_n = 1'b0; stall = 1'b0; f_valid = 1'b0; f_pc = '0; exc_ack = 1'b0;
    clear_flags();

    // Reset with random flags toggling
    for (int i = 0; i < 6; i++) begin
      f_valid = 1'($urandom);
      f_pc = $urandom;
      {addr_err_f, cache_err_f, bus_err_f} = 3'($urandom);
      {cp0_unused, instr_undefine, syscall, break_point} = 4'($urandom);
      {overflow, trap} = 2'($urandom);
      {addr_err_m, cache_err_m, bus_err_m} = 3'($urandom);
      exc_ack = 1'($urandom);
      step();
      check("rst_req", 32'(exc_req), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_excode", 32'(excode), 32'd0);
      check("rst_epc", exc_epc, 32'd0);
    end
    f_valid = 1'b0; f_pc = '0; exc_ack = 1'b0;
    clear_flags();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_req", 32'(exc_req), 32'd0);
    end

    // Table: one instruction, flags presented as it passes each stage
    for (int i = 0; i < 13; i++) begin
      f_valid = 1'b1; f_pc = vecs[i].pc;
      {addr_err_f, cache_err_f, bus_err_f} = vecs[i].f;
      step();
      clear_flags(); f_valid = 1'b0; f_pc = '0;
      {cp0_unused, instr_undefine, syscall, break_point} = vecs[i].d;
      step();
      clear_flags();
      {overflow, trap} = vecs[i].e;
      step();
      check("pre_commit_req", 32'(exc_req), 32'd0);
      clear_flags();
      {addr_err_m, cache_err_m, bus_err_m} = vecs[i].m;
      step();
      clear_flags();
      if (vecs[i].code != 5'd0) begin
        check("vec_req", 32'(exc_req), 32'd1);
        check("vec_flush", 32'(flush), 32'd1);
        check("vec_excode", 32'(excode), 32'(vecs[i].code));
        check("vec_epc", exc_epc, vecs[i].pc);
        step();
        check("vec_req_hold", 32'(exc_req), 32'd1);
        do_ack();
      end else begin
        check("vec_noreq", 32'(exc_req), 32'd0);
        step();
        check("vec_noreq2", 32'(exc_req), 32'd0);
      end
    end

    // Stall hold: trap instruction parked in M under stall
    f_valid = 1'b1; f_pc = 32'h400;
    step();
    f_valid = 1'b0; f_pc = '0;
    step();
    trap = 1'b1;
    step();
    trap = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_noreq", 32'(exc_req), 32'd0);
    end
    stall = 1'b0;
    step();
    check("stall_req", 32'(exc_req), 32'd1);
    check("stall_excode", 32'(excode), 32'd7);
    check("stall_epc", exc_epc, 32'h400);
    stall = 1'b1;
    step();
    check("req_ignores_stall", 32'(exc_req), 32'd1);
    stall = 1'b0;
    do_ack();

    // Squash: 0x300 faults in D, younger 0x304 overflow must vanish
    f_valid = 1'b1; f_pc = 32'h300;
    step();
    f_pc = 32'h304; instr_undefine = 1'b1;
    step();
    instr_undefine = 1'b0; f_valid = 1'b0; f_pc = '0;
    step();
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("sq_req", 32'(exc_req), 32'd1);
      check("sq_excode", 32'(excode), 32'd5);
      check("sq_epc", exc_epc, 32'h300);
      step();
    end
    do_ack();
    for (int i = 0; i < 10; i++) begin
      step();
      check("sq_no_younger", 32'(exc_req), 32'd0);
    end
    check("sq_excode_kept", 32'(excode), 32'd5);

    // Async reset mid-request
    f_valid = 1'b1; f_pc = 32'h500; addr_err_f = 1'b1;
    step();
    f_valid = 1'b0; f_pc = '0; clear_flags();
    step(); step(); step();
    check("ar_req_set", 32'(exc_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_req", 32'(exc_req), 32'd0);
    check("ar_flush", 32'(flush), 32'd0);
    check("ar_excode", 32'(excode), 32'd0);
    check("ar_epc", exc_epc, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_after", 32'(exc_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_encode.md
# exc_encode

Exception cause encoder and request generator for the CP0 path. It collects per-stage exception flags (fetch, decode, execute, memory) and carries them down a shadow pipeline aligned with the instruction stream. At the memory stage it resolves the architectural cause into the 5-bit `excode` that `exc_decode` consumes, then holds a request to CP0 until that request is acknowledged.

## Interface
- `PC_W`, default 32: width of the PC carried with each instruction and reported as EPC.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: pipeline hold; while high, the D/E/M shadow registers keep their contents.
- `f_valid` input 1: a valid instruction is present in F.
- `f_pc` input PC_W: PC of the F instruction.
- `addr_err_f`, `cache_err_f`, `bus_err_f` input 1 each: fetch-stage exception flags.
- `cp0_unused`, `instr_undefine`, `syscall`, `break_point` input 1 each: D-stage exception flags.
- `overflow`, `trap` input 1 each: E-stage exception flags.
- `addr_err_m`, `cache_err_m`, `bus_err_m` input 1 each: M-stage exception flags.
- `exc_ack` input 1: CP0 has accepted the pending exception.
- `exc_req` output 1: exception pending toward CP0.
- `excode` output 5: encoded cause; valid while `exc_req` is high.
- `exc_epc` output PC_W: PC of the excepting instruction.
- `flush` output 1: kill the pipeline; equal to `exc_req`.

## Operation
- Code map (0 = none):
  - addr_err_f = 1, cache_err_f = 2, bus_err_f = 3
  - cp0_unused = 4, instr_undefine = 5, overflow = 6, trap = 7, syscall = 8, break_point = 9
  - addr_err_m = 10, cache_err_m = 11, bus_err_m = 12
  - Codes 13–31 are never produced.
- Stage encoders: within a stage, the lowest code among the asserted flags wins.
- Shadow registers D, E, M each hold {valid, pc, code[4:0]}.
- Advance rule (IDLE state, `stall`=0), applied each cycle:
  - D ← {f_valid, f_pc, enc_F}.
  - E ← {D.valid, D.pc, D.code ? D.code : enc_D}.
  - M ← {E.valid, E.pc, E.code ? E.code : enc_E}.
- An earlier-stage cause always overrides a later one for the same instruction. A stage's flags are ignored when that stage's valid bit is 0.
- Commit resolution: `code_m = M.code ? M.code : enc_M`.
- FSM, two states:
  - IDLE: when `M.valid`=1, `code_m`≠0 and `stall`=0, go to REQ. On that edge, register `excode`←code_m and `exc_epc`←M.pc, and clear D/E/M valid.
  - REQ: `exc_req`=`flush`=1. All stage valids are held at 0; `f_valid` and every flag input are ignored; `stall` has no effect. When `exc_ack`=1, go to IDLE.
- In IDLE with `stall`=1, no commit happens, even if `code_m`≠0. The request is raised on the first unstalled cycle.
- `excode` and `exc_epc` keep their last values after REQ is left; consumers qualify them with `exc_req`.

## Timing
- Reset values: state IDLE; all valid bits 0; all codes 0; pc registers 0; `exc_req`=0, `flush`=0, `excode`=0, `exc_epc`=0.
- An instruction accepted in F at edge N reaches M at edge N+3, assuming no stalls.
- Latency: `exc_req` rises on the edge that commits the M instruction. An F-stage fault presented with `f_valid` at cycle 0 gives `exc_req`=1 after the 4th edge, assuming no stalls.
- `exc_ack` is sampled only in REQ. With `exc_ack` high in the first REQ cycle, `exc_req` is high for exactly one cycle. `exc_ack` in IDLE is ignored.
- The cycle after returning to IDLE, the pipeline refills from F. The first new commit is possible 3 edges later.
- Reset asserted mid-REQ: outputs clear immediately (asynchronously) with no ack needed.
- Younger instructions behind an excepting M instruction are discarded and never raise a request.

## Test plan
- Reset sequence: hold `rst_n`=0 with random flags toggling → all outputs 0. Release with no flags → `exc_req` stays 0 for 20 cycles.
- Fetch fault priority: `f_valid`=1, `f_pc`=0x100, `cache_err_f`=`bus_err_f`=1, no stalls → after the 4th edge `exc_req`=1, `excode`=2, `exc_epc`=0x100, `flush`=1. `exc_ack` one cycle later → `exc_req`=0.
- Earliest-stage wins:
  - Stimulus: instruction pc 0x200 with `syscall` in D, then `overflow` in E, then `bus_err_m` in M.
  - Response: `excode`=8, `exc_epc`=0x200.
- Stall hold: an instruction with `trap` reaches M while `stall`=1 for 3 cycles → no request during the stall. `exc_req` rises on the edge after `stall` falls, with `excode`=7.
- Squash and ack hold: back-to-back instructions 0x300 (`instr_undefine` in D) and 0x304 (`overflow` in E). Hold `exc_ack`=0 for 5 cycles → `excode`=5 and `exc_epc`=0x300 are held with `exc_req`=1 throughout. After ack, no request for 0x304 ever appears.
- Async reset mid-REQ: drop `rst_n` while `exc_req`=1 with no ack → `exc_req`, `flush` and `excode` go to 0 before the next clock edge.
